fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage that sits directly upstream of decode/control.
- Owns the PC and issues in-order requests to instruction memory over a req/gnt + rvalid interface.
- Buffers returned instructions in a small FIFO and presents {pc, insn} to decode with valid/ready.
- Accepts redirects from the branch/jump resolution path and discards wrong-path fetches.

Parameters:
DWIDTH, 32, instruction/data width
AWIDTH, 32, address width
BASE_ADDR, 32'h0100_0000, PC value after reset
FIFO_DEPTH, 2, instruction buffer entries; also the maximum number of outstanding requests

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
imem_req_o  output  1  fetch request valid
imem_addr_o  output  AWIDTH  fetch address, word-aligned
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response valid; responses return in order, at least 1 cycle after grant
imem_rdata_i  input  DWIDTH  response instruction word
redirect_i  input  1  taken branch/jump, one-cycle pulse
redirect_pc_i  input  AWIDTH  redirect target
valid_o  output  1  insn_o/pc_o valid to decode
ready_i  input  1  decode accepts the current instruction
insn_o  output  DWIDTH  instruction to decode
pc_o  output  AWIDTH  PC of insn_o
misaligned_o  output  1  one-cycle pulse when redirect_pc_i[1:0] != 0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Reset values:
  - fetch PC = BASE_ADDR; imem_req_o = 0; imem_addr_o = BASE_ADDR.
  - valid_o = 0; insn_o = NOP (32'h0000_0013); pc_o = BASE_ADDR; misaligned_o = 0.
  - FIFO empty; outstanding = 0; drop_cnt = 0; state = BOOT.
- FSM states:
  - BOOT: exactly one cycle after reset_n deasserts, then RUN. No requests are issued in BOOT.
  - RUN: normal fetching.
  - FLUSH: entered when a redirect occurs while stale requests are still in flight. No requests are issued. Stale responses are dropped, decrementing drop_cnt. Exit to RUN in the cycle after drop_cnt reaches 0.
- Request rule (RUN only):
  - imem_req_o = 1 iff outstanding + fifo_count < FIFO_DEPTH (credit scheme; a response never finds the FIFO full).
  - imem_addr_o and imem_req_o hold stable while req && !gnt.
  - On grant: PC += 4, outstanding++.
  - No PC wrap checking: 32-bit modular add.
- Response rule:
  - If drop_cnt > 0, the response is discarded and drop_cnt-- (outstanding-- as well).
  - Otherwise it is pushed to the FIFO as {fetch_pc_of_request, imem_rdata_i} and outstanding--.
  - Request PCs are tracked in a FIFO_DEPTH-deep in-flight PC queue.
- Decode handshake:
  - valid_o = FIFO non-empty; insn_o/pc_o = FIFO head.
  - Pop on valid_o && ready_i.
  - While stalled, outputs hold stable.
- Empty-FIFO bypass: none. Minimum latency is grant-to-rvalid + 1 cycle to valid_o, because FIFO output is registered.
- Redirect (highest priority, any state except BOOT):
  - FIFO is flushed and valid_o = 0 next cycle.
  - PC = {redirect_pc_i[AWIDTH-1:2], 2'b00}.
  - drop_cnt = outstanding (after this cycle's grant/rvalid updates). Go to FLUSH if nonzero, else RUN.
  - A request granted in the redirect cycle counts as stale.
  - A response arriving in the redirect cycle is discarded.
  - A decode pop in the redirect cycle is still honoured (decode already consumed it).
  - misaligned_o pulses one cycle if redirect_pc_i[1:0] != 0.
- Redirect during FLUSH: new target replaces PC; drop_cnt becomes the current outstanding count.
- Reset mid-operation: everything returns to reset values immediately. Any memory response after reset is ignored because outstanding = 0.
- Invariant: a response arriving with outstanding = 0 is an assertion error.

Decomposition:
- Shared package (constants.svh): NOP_INSN, BASE_ADDR default, fetch_state_e {BOOT, RUN, FLUSH}, fetch_entry_t {pc, insn}.
- Sub-module: fetch_fifo, a parameterised FIFO of fetch_entry_t with push/pop/flush/count. It is reused for both the instruction buffer and the in-flight PC queue.

Test Plan:
- Reset release, gnt=1 always, rvalid 1 cycle after gnt, ready=1 → BOOT 1 cycle, then addresses 0x0100_0000, 0x0100_0004, ...; first valid_o carries pc_o=0x0100_0000, followed by one instruction per cycle.
- ready_i=0 for 5 cycles → at most 2 instructions buffered, imem_req_o drops to 0, insn_o/pc_o stable; on release, in-order drain with no loss or duplication.
- gnt held low 3 cycles → imem_addr_o constant across the stall; PC advances only after the grant.
- redirect_i to 0x0100_0100 with 2 outstanding → FLUSH; the 2 stale responses are dropped, the next request is 0x0100_0100, and the first valid_o shows pc_o=0x0100_0100.
- redirect_pc_i=0x0100_0102 → misaligned_o pulses 1 cycle; fetch proceeds at 0x0100_0100.
- reset_n asserted mid-FLUSH with a pending rvalid → outputs at reset values that same cycle; after release, fetch restarts at BASE_ADDR and the late response is ignored.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: the reset-time
// constants, the fetch FSM state encoding and the {pc, insn} record that
// travels from instruction memory to decode.
package fetch_stage_pkg;

   // Canonical RISC-V no-op (addi x0, x0, 0), shown to decode before the
   // first real instruction arrives.
   localparam logic [31:0] NOP_INSN          = 32'h0000_0013;
   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0100_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used by the fetch stage, both for the decode-side
// instruction buffer and for the queue of PCs whose memory requests are in
// flight.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   push_i/data_i write an entry (ignored when full unless popping too)
//   pop_i         drop the head entry (ignored when empty)
//   flush_i       discard every entry; takes priority over push/pop
//   data_o        head entry, straight from storage (registered)
//   count_o       number of valid entries
module fetch_fifo #(
   parameter int              WIDTH     = 64,
   parameter int              DEPTH     = 2,
   parameter int              CNT_W     = $clog2(DEPTH + 1),
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (flush_i) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d        = ptr_inc(wr_q);
         end
         if (do_pop) begin
            rd_d = ptr_inc(rd_q);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage is reset as well so the head shows RESET_VAL out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= RESET_VAL;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   assign data_o  = mem_q[rd_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order requests to
// instruction memory (req/gnt, in-order rvalid), buffers the returned words
// and hands {pc, insn} to decode with valid/ready. Redirects from branch
// resolution restart fetch and discard every request still in flight.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   imem_req_o/imem_addr_o    fetch request and word-aligned address
//   imem_gnt_i                request accepted this cycle
//   imem_rvalid_i/rdata_i     in-order response
//   redirect_i/redirect_pc_i  taken branch/jump pulse and its target
//   valid_o/ready_i           decode handshake for insn_o/pc_o
//   misaligned_o              pulse after a redirect to a non-word target
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                DWIDTH     = 32,
   parameter int                AWIDTH     = 32,
   parameter logic [AWIDTH-1:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              imem_req_o,
   output logic [AWIDTH-1:0] imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [DWIDTH-1:0] imem_rdata_i,
   input  logic              redirect_i,
   input  logic [AWIDTH-1:0] redirect_pc_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DWIDTH-1:0] insn_o,
   output logic [AWIDTH-1:0] pc_o,
   output logic              misaligned_o
);

   localparam int                  CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam int                  ENTRY_W   = AWIDTH + DWIDTH;
   localparam logic [CNT_W:0]      DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [ENTRY_W-1:0]  BUF_RESET = {BASE_ADDR, DWIDTH'(NOP_INSN)};

   fetch_state_e      state_q, state_d;
   logic [AWIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  out_q, out_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic              misaligned_q, misaligned_d;

   logic               redirect_act, grant, resp_live, resp_keep, dec_pop;
   logic [CNT_W:0]     credit_used;
   logic [CNT_W-1:0]   buf_count, pcq_count;
   logic [ENTRY_W-1:0] buf_head;
   logic [AWIDTH-1:0]  pcq_head;

   // Every outstanding request already owns a buffer slot, so a returning
   // word can always be accepted. All terms are registered, which keeps
   // req/addr stable while memory withholds the grant.
   assign credit_used  = {1'b0, out_q} + {1'b0, buf_count};
   assign imem_req_o   = (state_q == RUN) && (credit_used < DEPTH_C);
   assign imem_addr_o  = pc_q;
   assign grant        = imem_req_o && imem_gnt_i;

   assign redirect_act = redirect_i && (state_q != BOOT);
   // A response with nothing outstanding (e.g. left over from before a
   // reset) is ignored outright.
   assign resp_live    = imem_rvalid_i && (out_q != '0) && (state_q != BOOT);
   assign resp_keep    = resp_live && !redirect_act && (drop_q == '0);
   assign dec_pop      = valid_o && ready_i;

   // PCs of live requests; stale requests are tracked only by drop_cnt,
   // so this queue is flushed on redirect and a grant in that cycle is not
   // recorded.
   fetch_fifo #(
      .WIDTH     (AWIDTH),
      .DEPTH     (FIFO_DEPTH),
      .CNT_W     (CNT_W),
      .RESET_VAL (BASE_ADDR)
   ) u_pc_queue (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (grant && !redirect_act),
      .data_i  (pc_q),
      .pop_i   (resp_keep),
      .flush_i (redirect_act),
      .data_o  (pcq_head),
      .count_o (pcq_count)
   );

   fetch_fifo #(
      .WIDTH     (ENTRY_W),
      .DEPTH     (FIFO_DEPTH),
      .CNT_W     (CNT_W),
      .RESET_VAL (BUF_RESET)
   ) u_insn_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (resp_keep),
      .data_i  ({pcq_head, imem_rdata_i}),
      .pop_i   (dec_pop),
      .flush_i (redirect_act),
      .data_o  (buf_head),
      .count_o (buf_count)
   );

   // FSM and PC/credit bookkeeping. A redirect overrides everything else;
   // the drop count it loads already includes this cycle's grant and
   // excludes this cycle's (discarded) response.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drop_d       = drop_q;
      out_d        = out_q + CNT_W'(grant) - CNT_W'(resp_live);
      misaligned_d = redirect_act && (redirect_pc_i[1:0] != 2'b00);
      if (state_q == BOOT) begin
         state_d = RUN;
      end else if (redirect_act) begin
         pc_d    = {redirect_pc_i[AWIDTH-1:2], 2'b00};
         drop_d  = out_d;
         state_d = (out_d != '0) ? FLUSH : RUN;
      end else begin
         if (grant) begin
            pc_d = pc_q + AWIDTH'(4);
         end
         if (resp_live && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
         end
         if ((state_q == FLUSH) && (drop_d == '0)) begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= BOOT;
         pc_q         <= BASE_ADDR;
         out_q        <= '0;
         drop_q       <= '0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         out_q        <= out_d;
         drop_q       <= drop_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign valid_o      = (buf_count != '0);
   assign pc_o         = buf_head[ENTRY_W-1:DWIDTH];
   assign insn_o       = buf_head[DWIDTH-1:0];
   assign misaligned_o = misaligned_q;

   a_resp_has_credit : assert property (@(posedge clk) disable iff (!reset_n)
      (imem_rvalid_i && (state_q != BOOT)) |-> (out_q != '0));

   a_inflight_accounting : assert property (@(posedge clk) disable iff (!reset_n)
      out_q == (pcq_count + drop_q));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. Stimulus phases push the hand-derived
// request addresses and decode entries they expect; a memory model answers
// grants in order after a programmable latency, and a negedge monitor pops
// the entry scoreboard whenever decode takes an instruction.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam logic [31:0] BASE = 32'h0100_0000;

   logic        clk;
   logic        reset_n;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] insn_o;
   logic [31:0] pc_o;
   logic        misaligned_o;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] due;
   } mem_req_t;

   fetch_entry_t expQ[$];
   logic [31:0]  expAddrQ[$];
   mem_req_t     memQ[$];
   fetch_entry_t monEntry;

   int checks;
   int passes;
   int cyc;
   int budget;
   int memLat;

   fetch_stage dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .insn_o        (insn_o),
      .pc_o          (pc_o),
      .misaligned_o  (misaligned_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction word memory returns for a given address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic pushAddr(input logic [31:0] a);
      expAddrQ.push_back(a);
   endtask

   task automatic pushData(input logic [31:0] a);
      expQ.push_back('{pc: a, insn: memWord(a)});
   endtask

   // One clock cycle: drive inputs 2 time units after the rising edge, let
   // the async reset settle, then play the memory side for this cycle.
   task automatic applyStimulus(input bit gnt, input bit rdy, input bit redir,
                                input logic [31:0] rpc, input bit rstN);
      @(posedge clk);
      #2;
      cyc++;
      reset_n       = rstN;
      ready_i       = rdy;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      #1;
      if (memQ.size() != 0 && int'(memQ[0].due) <= cyc) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = memWord(memQ[0].addr);
         void'(memQ.pop_front());
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = '0;
      end
      imem_gnt_i = gnt && (budget > 0);
      if (imem_req_o && imem_gnt_i) begin
         budget--;
         memQ.push_back('{addr: imem_addr_o, due: 32'(cyc + memLat)});
         if (expAddrQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_req: got request at %h, expected none", imem_addr_o);
         end else begin
            checkOutput("req_addr", imem_addr_o, expAddrQ.pop_front());
         end
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_valid"},      32'(valid_o),      32'd0);
      checkOutput({tag, "_insn"},       insn_o,            NOP_INSN);
      checkOutput({tag, "_pc"},         pc_o,              BASE);
      checkOutput({tag, "_req"},        32'(imem_req_o),   32'd0);
      checkOutput({tag, "_addr"},       imem_addr_o,       BASE);
      checkOutput({tag, "_misaligned"}, 32'(misaligned_o), 32'd0);
   endtask

   // Run with gnt/ready high until every expected entry has reached decode
   // and memory has nothing left to return.
   task automatic drain(input string name);
      int n;
      n = 0;
      while ((expQ.size() != 0 || memQ.size() != 0) && n < 60) begin
         applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
         n++;
      end
      checks++;
      if (expQ.size() == 0 && memQ.size() == 0 && expAddrQ.size() == 0) passes++;
      else $display("[TB] FAIL %s_drain: got %0d entries/%0d requests pending after %0d cycles, expected 0/0",
                    name, expQ.size(), expAddrQ.size(), n);
   endtask

   // Decode-side monitor: every accepted instruction must be the next one
   // the scoreboard expects.
   always @(negedge clk) begin
      if (reset_n && valid_o && ready_i) begin
         if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_insn: got pc %h insn %h, expected none", pc_o, insn_o);
         end else begin
            monEntry = expQ.pop_front();
            checkOutput("dec_pc", pc_o, monEntry.pc);
            checkOutput("dec_insn", insn_o, monEntry.insn);
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks        = 0;
      passes        = 0;
      cyc           = 0;
      budget        = 0;
      memLat        = 1;
      reset_n       = 1'b0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      ready_i       = 1'b0;

      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      checkResetValues("reset");

      // Release reset: the first cycle is BOOT and must not request.
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
      checkOutput("boot_no_req", 32'(imem_req_o), 32'd0);

      $display("[TB] streaming fetch from BASE");
      budget = 6;
      for (int i = 0; i < 6; i++) begin
         pushAddr(BASE + 32'(4 * i));
         pushData(BASE + 32'(4 * i));
      end
      drain("stream");

      $display("[TB] decode backpressure");
      budget = 4;
      for (int i = 0; i < 4; i++) begin
         pushAddr(BASE + 32'h18 + 32'(4 * i));
         pushData(BASE + 32'h18 + 32'(4 * i));
      end
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checkOutput("stall_req",   32'(imem_req_o), 32'd0);
      checkOutput("stall_valid", 32'(valid_o),    32'd1);
      checkOutput("stall_pc",    pc_o,            BASE + 32'h18);
      checkOutput("stall_insn",  insn_o,          memWord(BASE + 32'h18));
      drain("backpressure");

      $display("[TB] grant stall");
      budget = 2;
      pushAddr(BASE + 32'h28);  pushData(BASE + 32'h28);
      pushAddr(BASE + 32'h2C);  pushData(BASE + 32'h2C);
      repeat (3) begin
         applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
         checkOutput("nognt_req",  32'(imem_req_o), 32'd1);
         checkOutput("nognt_addr", imem_addr_o,     BASE + 32'h28);
      end
      drain("gntstall");

      $display("[TB] redirect with two requests in flight");
      budget = 4;
      memLat = 3;
      pushAddr(BASE + 32'h30);
      pushAddr(BASE + 32'h34);
      pushAddr(BASE + 32'h100);  pushData(BASE + 32'h100);
      pushAddr(BASE + 32'h104);  pushData(BASE + 32'h104);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, BASE + 32'h100, 1'b1);
      checkOutput("credit_full_req", 32'(imem_req_o), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
      checkOutput("flush_req",   32'(imem_req_o), 32'd0);
      checkOutput("flush_valid", 32'(valid_o),    32'd0);
      memLat = 1;
      drain("redirect");

      $display("[TB] misaligned redirect");
      budget = 3;
      pushAddr(BASE + 32'h108);
      pushAddr(BASE + 32'h100);  pushData(BASE + 32'h100);
      pushAddr(BASE + 32'h104);  pushData(BASE + 32'h104);
      applyStimulus(1'b1, 1'b1, 1'b1, BASE + 32'h102, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
      checkOutput("misaligned_pulse", 32'(misaligned_o), 32'd1);
      checkOutput("misaligned_flush_req", 32'(imem_req_o), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
      checkOutput("misaligned_end", 32'(misaligned_o), 32'd0);
      drain("misaligned");

      $display("[TB] reset during flush");
      budget = 2;
      memLat = 5;
      pushAddr(BASE + 32'h108);
      pushAddr(BASE + 32'h10C);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
      memLat = 1;
      applyStimulus(1'b1, 1'b1, 1'b1, BASE + 32'h200, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
      checkResetValues("midreset");
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("reset_rvalid_valid", 32'(valid_o), 32'd0);
      budget = 2;
      pushAddr(BASE);          pushData(BASE);
      pushAddr(BASE + 32'h4);  pushData(BASE + 32'h4);
      applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);
      checkOutput("reboot_no_req", 32'(imem_req_o), 32'd0);
      drain("restart");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
